// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller: FSM states,
// active-low 7-segment patterns ({g,f,e,d,c,b,a}) and keypad helpers.
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOKING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index of the set bit of a one-hot keypad word.
  function automatic logic [3:0] key_digit(input logic [9:0] v);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) d = 4'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/microwave_seg7_decoder.sv
// BCD digit to active-low 7-segment pattern ({g,f,e,d,c,b,a}).
module seg7_decoder
  import microwave_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/microwave.sv
// Microwave oven controller: keypad M:SS entry, start/stop/clear buttons,
// door interlock, BCD countdown and three 7-segment digit outputs.
//
//   state   | meaning
//   IDLE    | time entry allowed, magnetron off
//   COOKING | counting down once per second, magnetron on while door closed
//   PAUSED  | time held, waiting for start (resume) or stop (back to IDLE)
module microwave
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keys,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       closed_door,
  output logic [6:0] units_sec_segments,
  output logic [6:0] tens_sec_segments,
  output logic [6:0] minutes_segments,
  output logic       magnetron
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

  logic [9:0]    r_keys, r_keys_prev;
  logic          r_start, r_start_prev;
  logic          r_stop, r_stop_prev;
  logic          r_clear, r_clear_prev;
  logic          r_door;
  state_t        r_state;
  logic [3:0]    r_min, r_tens, r_units;
  logic [TW-1:0] r_tick;
  logic          r_mag;

  state_t        w_state_next;
  logic [3:0]    w_min_next, w_tens_next, w_units_next;
  logic [TW-1:0] w_tick_next;
  logic [3:0]    w_dec_min, w_dec_tens, w_dec_units;
  logic          w_start_press, w_stop_press, w_clear_press, w_key_press;
  logic          w_time_zero, w_dec_zero, w_can_start, w_tick_done;

  // Buttons are active-low, so their registers reset to "released".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_keys       <= '0;
      r_keys_prev  <= '0;
      r_start      <= 1'b1;
      r_start_prev <= 1'b1;
      r_stop       <= 1'b1;
      r_stop_prev  <= 1'b1;
      r_clear      <= 1'b1;
      r_clear_prev <= 1'b1;
      r_door       <= 1'b0;
    end else begin
      r_keys       <= keys;
      r_keys_prev  <= r_keys;
      r_start      <= start;
      r_start_prev <= r_start;
      r_stop       <= stop;
      r_stop_prev  <= r_stop;
      r_clear      <= clear;
      r_clear_prev <= r_clear;
      r_door       <= closed_door;
    end
  end

  assign w_start_press = r_start_prev & ~r_start;
  assign w_stop_press  = r_stop_prev & ~r_stop;
  assign w_clear_press = r_clear_prev & ~r_clear;
  assign w_key_press   = (r_keys_prev == 10'd0) && $onehot(r_keys);
  assign w_time_zero   = (r_min == 4'd0) && (r_tens == 4'd0) && (r_units == 4'd0);
  assign w_can_start   = w_start_press && r_door && !w_time_zero;
  assign w_tick_done   = (r_tick == TICK_LAST);

  // Tens above 5 borrow only when they reach 0, so keyed-in 1:75 runs down naturally.
  always_comb begin
    w_dec_min   = r_min;
    w_dec_tens  = r_tens;
    w_dec_units = r_units - 4'd1;
    if (r_units == 4'd0) begin
      w_dec_units = 4'd9;
      if (r_tens == 4'd0) begin
        w_dec_tens = 4'd5;
        w_dec_min  = r_min - 4'd1;
      end else begin
        w_dec_tens = r_tens - 4'd1;
      end
    end
  end

  assign w_dec_zero = (w_dec_min == 4'd0) && (w_dec_tens == 4'd0) && (w_dec_units == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_min   <= 4'd0;
      r_tens  <= 4'd0;
      r_units <= 4'd0;
      r_tick  <= '0;
      r_mag   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_min   <= w_min_next;
      r_tens  <= w_tens_next;
      r_units <= w_units_next;
      r_tick  <= w_tick_next;
      r_mag   <= (w_state_next == COOKING) && closed_door;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_min_next   = r_min;
    w_tens_next  = r_tens;
    w_units_next = r_units;
    w_tick_next  = r_tick;
    if (w_clear_press) begin
      w_state_next = IDLE;
      w_min_next   = 4'd0;
      w_tens_next  = 4'd0;
      w_units_next = 4'd0;
      w_tick_next  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_stop_press) begin
            w_state_next = IDLE;
          end else if (w_can_start) begin
            w_state_next = COOKING;
            w_tick_next  = '0;
          end else if (w_key_press) begin
            w_min_next   = r_tens;
            w_tens_next  = r_units;
            w_units_next = key_digit(r_keys);
          end
        end
        COOKING: begin
          if (w_stop_press || !r_door) begin
            w_state_next = PAUSED;
          end else if (w_tick_done) begin
            w_tick_next  = '0;
            w_min_next   = w_dec_min;
            w_tens_next  = w_dec_tens;
            w_units_next = w_dec_units;
            if (w_dec_zero) w_state_next = IDLE;
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
        PAUSED: begin
          if (w_stop_press) begin
            w_state_next = IDLE;
          end else if (w_can_start) begin
            w_state_next = COOKING;
            w_tick_next  = '0;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign magnetron = r_mag;

  seg7_decoder u_seg_units (.i_bcd(r_units), .o_seg(units_sec_segments));
  seg7_decoder u_seg_tens  (.i_bcd(r_tens),  .o_seg(tens_sec_segments));
  seg7_decoder u_seg_min   (.i_bcd(r_min),   .o_seg(minutes_segments));

endmodule

// File: tb/tb_microwave.sv
// Self-checking bench for the microwave controller using a queue of expected
// display/magnetron snapshots compared as the DUT outputs change.
module tb_microwave;

  localparam int TPS = 10;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] keys;
  logic       start, stop, clear, closed_door;
  logic [6:0] units_sec_segments, tens_sec_segments, minutes_segments;
  logic       magnetron;

  int n_checks = 0;
  int n_fail   = 0;
  logic [21:0] sb_q[$];

  always #5 clk = ~clk;

  microwave #(.TICKS_PER_SEC(TPS)) dut (
    .clk                (clk),
    .reset              (reset),
    .keys               (keys),
    .start              (start),
    .stop               (stop),
    .clear              (clear),
    .closed_door        (closed_door),
    .units_sec_segments (units_sec_segments),
    .tens_sec_segments  (tens_sec_segments),
    .minutes_segments   (minutes_segments),
    .magnetron          (magnetron)
  );

  function automatic logic [21:0] exp_of(input int m, input int t, input int u, input logic mag);
    return {SEG_TAB[m], SEG_TAB[t], SEG_TAB[u], mag};
  endfunction

  function automatic logic [21:0] obs();
    return {minutes_segments, tens_sec_segments, units_sec_segments, magnetron};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input int d, input int hold);
    keys = 10'b1 << d;
    tick(hold);
    keys = '0;
    tick(3);
  endtask

  // which: 0 = start, 1 = stop, 2 = clear
  task automatic press_btn(input int which);
    case (which)
      0: start = 1'b0;
      1: stop  = 1'b0;
      default: clear = 1'b0;
    endcase
    tick(3);
    start = 1'b1;
    stop  = 1'b1;
    clear = 1'b1;
    tick(3);
  endtask

  task automatic wait_change(output logic [21:0] got, output bit timed_out);
    logic [21:0] last;
    int n;
    last = obs();
    n = 0;
    while (obs() === last && n < 3 * TPS) begin
      @(negedge clk);
      n++;
    end
    timed_out = (obs() === last);
    got = obs();
  endtask

  // Reference countdown: one second off an M:SS BCD time.
  task automatic bcd_dec(inout int m, inout int t, inout int u);
    if (u > 0) u--;
    else begin
      u = 9;
      if (t > 0) t--;
      else begin
        t = 5;
        m--;
      end
    end
  endtask

  task automatic push_countdown(input int m0, input int t0, input int u0, input int steps);
    int m, t, u;
    m = m0; t = t0; u = u0;
    for (int i = 0; i < steps; i++) begin
      bcd_dec(m, t, u);
      sb_q.push_back(exp_of(m, t, u, (m + t + u) != 0));
    end
  endtask

  task automatic test_reset;
    logic [21:0] e;
    keys = '0; start = 1'b1; stop = 1'b1; clear = 1'b1; closed_door = 1'b1;
    reset = 1'b1;
    #1;
    sb_q.push_back(exp_of(0, 0, 0, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset_asserted: got %h expected %h", obs(), e);
    end
    tick(2);
    reset = 1'b0;
    tick(3);
    sb_q.push_back(exp_of(0, 0, 0, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset_released: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_keypad;
    int digs [3] = '{1, 5, 0};
    logic [21:0] exps [3];
    logic [21:0] e;
    exps[0] = exp_of(0, 0, 1, 1'b0);
    exps[1] = exp_of(0, 1, 5, 1'b0);
    exps[2] = exp_of(1, 5, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      press_key(digs[i], 1);
      sb_q.push_back(exps[i]);
      e = sb_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL keypad_digit%0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_door_blocks_start;
    logic [21:0] e;
    closed_door = 1'b0;
    tick(2);
    press_btn(0);
    tick(2 * TPS);
    sb_q.push_back(exp_of(1, 5, 0, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL start_door_open: got %h expected %h", obs(), e);
    end
    closed_door = 1'b1;
    tick(2 * TPS);
    sb_q.push_back(exp_of(1, 5, 0, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL start_not_remembered: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_cook_150;
    logic [21:0] got, e;
    bit to;
    int step;
    press_btn(0);
    sb_q.push_back(exp_of(1, 5, 0, 1'b1));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL cook150_start: got %h expected %h", obs(), e);
    end
    push_countdown(1, 5, 0, 110);
    step = 0;
    while (sb_q.size() > 0) begin
      wait_change(got, to);
      e = sb_q.pop_front();
      n_checks++;
      if (to || got !== e) begin
        n_fail++;
        $display("FAIL cook150_step%0d: got %h expected %h timeout=%0d", step, got, e, to);
      end
      step++;
    end
  endtask

  task automatic test_pause_resume;
    int digs [3] = '{2, 4, 5};
    logic [21:0] exps [3];
    logic [21:0] got, e;
    bit to;
    int step;
    exps[0] = exp_of(0, 0, 2, 1'b0);
    exps[1] = exp_of(0, 2, 4, 1'b0);
    exps[2] = exp_of(2, 4, 5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      press_key(digs[i], 2);
      sb_q.push_back(exps[i]);
      e = sb_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL entry245_digit%0d: got %h expected %h", i, obs(), e);
      end
    end
    press_btn(0);
    push_countdown(2, 4, 5, 30);
    step = 0;
    while (sb_q.size() > 0) begin
      wait_change(got, to);
      e = sb_q.pop_front();
      n_checks++;
      if (to || got !== e) begin
        n_fail++;
        $display("FAIL cook245_step%0d: got %h expected %h timeout=%0d", step, got, e, to);
      end
      step++;
    end
    closed_door = 1'b0;
    @(negedge clk);
    n_checks++;
    if (magnetron !== 1'b0) begin
      n_fail++;
      $display("FAIL door_open_mag_1cycle: got %b expected 0", magnetron);
    end
    tick(2 * TPS);
    sb_q.push_back(exp_of(2, 1, 5, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL door_open_frozen: got %h expected %h", obs(), e);
    end
    press_btn(0);
    tick(2 * TPS);
    sb_q.push_back(exp_of(2, 1, 5, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL paused_start_door_open: got %h expected %h", obs(), e);
    end
    closed_door = 1'b1;
    tick(2 * TPS);
    sb_q.push_back(exp_of(2, 1, 5, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL door_close_no_resume: got %h expected %h", obs(), e);
    end
    press_btn(0);
    sb_q.push_back(exp_of(2, 1, 5, 1'b1));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL resume_start: got %h expected %h", obs(), e);
    end
    push_countdown(2, 1, 5, 135);
    step = 0;
    while (sb_q.size() > 0) begin
      wait_change(got, to);
      e = sb_q.pop_front();
      n_checks++;
      if (to || got !== e) begin
        n_fail++;
        $display("FAIL resume_step%0d: got %h expected %h timeout=%0d", step, got, e, to);
      end
      step++;
    end
  endtask

  task automatic test_stop;
    logic [21:0] got, e;
    bit to;
    press_key(1, 1);
    press_key(2, 1);
    sb_q.push_back(exp_of(0, 1, 2, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL entry012: got %h expected %h", obs(), e);
    end
    press_btn(0);
    sb_q.push_back(exp_of(0, 1, 1, 1'b1));
    wait_change(got, to);
    e = sb_q.pop_front();
    n_checks++;
    if (to || got !== e) begin
      n_fail++;
      $display("FAIL stop_pre_tick: got %h expected %h timeout=%0d", got, e, to);
    end
    press_btn(1);
    tick(2 * TPS);
    sb_q.push_back(exp_of(0, 1, 1, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL stop_paused_held: got %h expected %h", obs(), e);
    end
    press_key(7, 2);
    sb_q.push_back(exp_of(0, 1, 1, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL key_ignored_paused: got %h expected %h", obs(), e);
    end
    press_btn(1);
    press_key(4, 2);
    sb_q.push_back(exp_of(1, 1, 4, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL stop_to_idle_key: got %h expected %h", obs(), e);
    end
    press_btn(2);
    sb_q.push_back(exp_of(0, 0, 0, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL clear_zero: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_zero_and_multikey;
    logic [21:0] e;
    press_btn(0);
    tick(2 * TPS);
    sb_q.push_back(exp_of(0, 0, 0, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL start_at_zero: got %h expected %h", obs(), e);
    end
    keys = 10'b01_0000_0100;
    tick(5);
    keys = '0;
    tick(3);
    sb_q.push_back(exp_of(0, 0, 0, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL two_keys_ignored: got %h expected %h", obs(), e);
    end
    press_key(9, 100);
    sb_q.push_back(exp_of(0, 0, 9, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL held_key_once: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_reset_mid_cook;
    logic [21:0] got, e;
    bit to;
    press_key(5, 1);
    press_btn(0);
    sb_q.push_back(exp_of(0, 9, 4, 1'b1));
    wait_change(got, to);
    e = sb_q.pop_front();
    n_checks++;
    if (to || got !== e) begin
      n_fail++;
      $display("FAIL cook095_first: got %h expected %h timeout=%0d", got, e, to);
    end
    press_key(3, 1);
    sb_q.push_back(exp_of(0, 9, 3, 1'b1));
    wait_change(got, to);
    e = sb_q.pop_front();
    n_checks++;
    if (to || got !== e) begin
      n_fail++;
      $display("FAIL key_ignored_cooking: got %h expected %h timeout=%0d", got, e, to);
    end
    tick(2);
    reset = 1'b1;
    #1;
    sb_q.push_back(exp_of(0, 0, 0, 1'b0));
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset_mid_cook: got %h expected %h", obs(), e);
    end
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset;
    test_keypad;
    test_door_blocks_start;
    test_cook_150;
    test_pause_resume;
    test_stop;
    test_zero_and_multikey;
    test_reset_mid_cook;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
